// File: rtl/npu_bus_frontend.sv
// NPU responder on the shared we/oe host bus: parses config/weights/inputs, returns PE results.
// Build with NPU_FE_PROTO_CHECK_EN defined to get the sticky protocol error flag on err.
module npu_bus_frontend #(
    parameter int DATA_W     = 32,
    parameter int FIELD_W    = 5,
    parameter int OBUF_DEPTH = 32,
    parameter int WCNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              oe,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              cfg_valid,
    output logic [1:0]        cfg_layers,
    output logic [FIELD_W-1:0] cfg_n_in,
    output logic [FIELD_W-1:0] cfg_n_h1,
    output logic [FIELD_W-1:0] cfg_n_h2,
    output logic [FIELD_W-1:0] cfg_n_out,
    output logic              cfg_act,
    output logic              wgt_valid,
    output logic [DATA_W-1:0] wgt_data,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_CFG  = 3'd2;
    localparam logic [2:0] S_WGT  = 3'd3;
    localparam logic [2:0] S_INP  = 3'd4;
    localparam logic [2:0] S_CALC = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam logic [WCNT_W-1:0] ONE = WCNT_W'(1);

    logic [2:0]         state;
    logic [2:0]         cidx;
    logic [WCNT_W-1:0]  wcnt;
    logic [WCNT_W-1:0]  wgt_total;
    logic [WCNT_W-1:0]  wgt_calc;
    logic [FIELD_W-1:0] icnt;
    logic [FIELD_W-1:0] wr;
    logic [FIELD_W-1:0] rd;
    logic [DATA_W-1:0]  obuf [OBUF_DEPTH];

    logic [WCNT_W-1:0] s_in, s_h1, s_h2, s_out;

    assign s_in  = WCNT_W'(cfg_n_in) + ONE;
    assign s_h1  = WCNT_W'(cfg_n_h1) + ONE;
    assign s_h2  = WCNT_W'(cfg_n_h2) + ONE;
    assign s_out = WCNT_W'(cfg_n_out) + ONE;

    // Each layer carries one bias word per destination neuron on top of its weights.
    always_comb begin
        wgt_calc = '0;
        unique case (cfg_layers)
            2'd0:    wgt_calc = (s_in + ONE) * s_out;
            2'd1:    wgt_calc = (s_in + ONE) * s_h1 + (s_h1 + ONE) * s_out;
            default: wgt_calc = (s_in + ONE) * s_h1 + (s_h1 + ONE) * s_h2
                              + (s_h2 + ONE) * s_out;
        endcase
    end

    assign data = (oe && state == S_OUT) ? obuf[rd] : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (state == S_CALC && res_valid)
            obuf[wr] <= res_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cidx       <= '0;
            wcnt       <= '0;
            wgt_total  <= '0;
            icnt       <= '0;
            wr         <= '0;
            rd         <= '0;
            ready      <= 1'b0;
            cfg_valid  <= 1'b0;
            cfg_layers <= '0;
            cfg_n_in   <= '0;
            cfg_n_h1   <= '0;
            cfg_n_h2   <= '0;
            cfg_n_out  <= '0;
            cfg_act    <= 1'b0;
            wgt_valid  <= 1'b0;
            wgt_data   <= '0;
            in_valid   <= 1'b0;
            in_data    <= '0;
        end else begin
            cfg_valid <= 1'b0;
            wgt_valid <= 1'b0;
            in_valid  <= 1'b0;
            unique case (state)
                S_IDLE: if (we) state <= S_PRE;
                S_PRE: if (we) begin
                    cfg_layers <= (data > DATA_W'(2)) ? 2'd2 : data[1:0];
                    cidx       <= 3'd1;
                    state      <= S_CFG;
                end
                S_CFG: if (we) begin
                    cidx <= cidx + 3'd1;
                    unique case (cidx)
                        3'd1:    cfg_n_in  <= data[FIELD_W-1:0];
                        3'd2:    cfg_n_h1  <= data[FIELD_W-1:0];
                        3'd3:    cfg_n_h2  <= data[FIELD_W-1:0];
                        3'd4:    cfg_n_out <= data[FIELD_W-1:0];
                        default: begin
                            cfg_act   <= data[0];
                            cfg_valid <= 1'b1;
                            wgt_total <= wgt_calc;
                            wcnt      <= '0;
                            state     <= S_WGT;
                        end
                    endcase
                end
                S_WGT: if (we) begin
                    wgt_valid <= 1'b1;
                    wgt_data  <= data;
                    if (wcnt == wgt_total - ONE) begin
                        wcnt  <= '0;
                        icnt  <= '0;
                        state <= S_INP;
                    end else begin
                        wcnt <= wcnt + ONE;
                    end
                end
                S_INP: if (we) begin
                    in_valid <= 1'b1;
                    in_data  <= data;
                    if (icnt == cfg_n_in) begin
                        icnt  <= '0;
                        wr    <= '0;
                        state <= S_CALC;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                S_CALC: if (res_valid) begin
                    if (wr == cfg_n_out) begin
                        ready <= 1'b1;
                        rd    <= '0;
                        state <= S_OUT;
                    end else begin
                        wr <= wr + 1'b1;
                    end
                end
                S_OUT: if (oe) begin
                    if (rd == cfg_n_out) begin
                        ready <= 1'b0;
                        rd    <= '0;
                        wr    <= '0;
                        state <= S_IDLE;
                    end else begin
                        rd <= rd + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NPU_FE_PROTO_CHECK_EN
    logic proto_bad;

    assign proto_bad =
        (!we && (state == S_CFG || state == S_WGT || state == S_INP)) ||
        (we && (state == S_CALC || state == S_OUT)) ||
        (res_valid && state != S_CALC) ||
        (we && state == S_PRE && data > DATA_W'(2)) ||
        (oe && state != S_OUT);

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (proto_bad)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
